uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receiver: the receive-side counterpart of the Tx BaudGen/transmitter chain on a 50 MHz system clock.
//  Recovers 8N1/8O1/8E1 frames from rx_serial using a 16x oversampling tick generator selected by baud_rate.
//  Delivers each byte with status flags through a valid/ack handshake.
// PARAMETERS
//  DIV_2400   1302  clocks per 16x tick at 2400 baud
//  DIV_4800    651  clocks per 16x tick at 4800 baud
//  DIV_9600    326  clocks per 16x tick at 9600 baud
//  DIV_19200   163  clocks per 16x tick at 19200 baud
// PORTS
//  clock          in   1  system clock, 50 MHz
//  reset_n        in   1  asynchronous, active-low reset
//  baud_rate      in   2  00=2400 01=4800 10=9600 11=19200
//  parity_type    in   2  00=none 01=odd 10=even 11=none
//  rx_serial      in   1  serial line; idle high; asynchronous to clock
//  data_ack       in   1  consumer accepts data_out; one-cycle pulse
//  data_out       out  8  received byte, LSB received first
//  data_valid     out  1  data_out and flags valid; held until data_ack
//  parity_error   out  1  parity mismatch on the frame in data_out
//  frame_error    out  1  stop bit sampled low on the frame in data_out
//  overrun_error  out  1  frame completed while data_valid was already high
//  busy           out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async): all outputs 0, FSM=IDLE, divider=0, tick count=0, synchroniser FFs=1.
//  rx_serial passes through a 2-FF synchroniser. All decisions use the synchronised value rxs.
//  Divider: 11-bit counter, 0..DIV-1. tick=1 for one clock when count==DIV-1, then wraps to 0.
//  baud_rate and parity_type are latched on start detection and are stable for the whole frame.
//  Changes to those inputs mid-frame take effect on the next frame.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  IDLE: on rxs 1->0, clear divider and tick_cnt (4b), latch config, -> START.
//  START: at tick_cnt==7 (bit centre), sample rxs.
//    1 -> glitch: back to IDLE, no flags change.
//    0 -> clear tick_cnt, -> DATA.
//  DATA: sample rxs every 16th tick (tick_cnt==15) into shift reg, LSB first.
//    After bit 7 -> PARITY if parity enabled, else -> STOP.
//  PARITY: sample at 16th tick. Even parity: error if ^data ^ bit != 0. Odd parity: error if == 0.
//    -> STOP.
//  STOP: sample at 16th tick, then commit, then -> IDLE.
//    Commit is registered, so outputs update 1 clock after the sample.
//    Commit writes data_out, parity_error (0 if no parity), frame_error = ~stop sample, data_valid=1.
//    overrun_error = data_valid && !data_ack at commit.
//    A new commit always overwrites data_out; the old byte is lost.
//  Returning to IDLE at stop centre allows a back-to-back start edge in the 2nd half of the stop bit.
//  frame_error frames are still committed. The FSM re-arms only after rxs is seen high in IDLE.
//    A falling edge is required, so a line stuck low produces no further frames.
//  Handshake: data_ack while data_valid=1 clears data_valid and overrun_error next clock.
//    data_out and the error flags hold.
//    data_ack and commit in the same cycle: commit wins, data_valid stays 1, overrun_error=0.
//    data_ack while data_valid=0 is ignored.
//  Reset mid-frame: immediate return to IDLE. Partial frame discarded; no flags.
//  Frame time at 9600, 8E1: 11 bits x 16 x 326 clocks. data_valid rises 1 clock after stop centre.
// TESTING
//  T1: 9600, even parity, send 0xA5 with parity 0 and stop 1.
//      -> data_out=A5, data_valid=1, all error flags 0.
//  T2: same frame with parity bit 1.
//      -> data_out=A5, parity_error=1, frame_error=0.
//  T3: 19200, no parity, 0x3C with stop bit 0.
//      -> data_out=3C, frame_error=1. No new frame until the line returns high.
//  T4: 2400, low glitch of 4x DIV_2400 clocks on idle line.
//      -> busy pulses, no data_valid, FSM back in IDLE.
//  T5: 4800, 0x11 then 0x22 back-to-back, no ack.
//      -> data_out=22, overrun_error=1. After data_ack: data_valid=0, overrun_error=0.
//  T6: reset_n low during DATA bit 4, then a full 0x7E frame.
//      -> outputs 0 during reset, then data_out=7E with no errors.

Source files
------------

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x-oversampled 8-bit UART receiver with parity, framing and overrun status

module uart_rx_core #(
   parameter int DIV_2400  = 1302,
   parameter int DIV_4800  = 651,
   parameter int DIV_9600  = 326,
   parameter int DIV_19200 = 163
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] baud_rate,
   input  logic [1:0] parity_type,
   input  logic       rx_serial,
   input  logic       data_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       overrun_error,
   output logic       busy
);

   // Terminal counts for the 16x tick divider (count runs 0..DIV-1)
   localparam logic [10:0] DIVM_2400  = 11'(DIV_2400 - 1);
   localparam logic [10:0] DIVM_4800  = 11'(DIV_4800 - 1);
   localparam logic [10:0] DIVM_9600  = 11'(DIV_9600 - 1);
   localparam logic [10:0] DIVM_19200 = 11'(DIV_19200 - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t      state_q;
   state_t      state_d;

   logic        sync_meta;
   logic        rxs;
   logic        rxs_d;
   logic        start_edge;

   logic [1:0]  baud_q;
   logic [1:0]  par_q;
   logic        parity_en;

   logic [10:0] div_cnt;
   logic [10:0] div_max;
   logic        tick;
   logic [3:0]  tick_cnt;
   logic        centre_tick;
   logic        full_tick;

   logic [2:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic        par_err_q;
   logic        stop_q;
   logic        commit_q;

   // Two-flop synchroniser plus one history flop for falling-edge detection; idle level is high
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b1;
         rxs       <= 1'b1;
         rxs_d     <= 1'b1;
      end else begin
         sync_meta <= rx_serial;
         rxs       <= sync_meta;
         rxs_d     <= rxs;
      end
   end

   // A start needs a real 1->0 transition, so a line stuck low never re-triggers
   assign start_edge = rxs_d & ~rxs;

   // Parity is only checked for the odd (01) and even (10) encodings
   assign parity_en = (par_q == 2'b01) || (par_q == 2'b10);

   // Divider terminal count for the baud rate captured at the start of the frame
   always_comb begin
      div_max = DIVM_9600;
      case (baud_q)
         2'b00:   div_max = DIVM_2400;
         2'b01:   div_max = DIVM_4800;
         2'b10:   div_max = DIVM_9600;
         default: div_max = DIVM_19200;
      endcase
   end

   assign tick        = (div_cnt == div_max);
   assign centre_tick = tick && (tick_cnt == 4'd7);
   assign full_tick   = tick && (tick_cnt == 4'd15);
   assign busy        = (state_q != ST_IDLE);

   // Frame configuration is frozen at start detection so mid-frame changes wait for the next frame
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         baud_q <= 2'b00;
         par_q  <= 2'b00;
      end else if (state_q == ST_IDLE && start_edge) begin
         baud_q <= baud_rate;
         par_q  <= parity_type;
      end
   end

   // 16x tick divider and tick counter; both held at zero while idle so a frame starts aligned
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt  <= 11'd0;
         tick_cnt <= 4'd0;
      end else if (state_q == ST_IDLE) begin
         div_cnt  <= 11'd0;
         tick_cnt <= 4'd0;
      end else if (tick) begin
         div_cnt <= 11'd0;
         if (state_q == ST_START && tick_cnt == 4'd7) begin
            tick_cnt <= 4'd0;
         end else begin
            tick_cnt <= tick_cnt + 4'd1;
         end
      end else begin
         div_cnt <= div_cnt + 11'd1;
      end
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: sample points are the start-bit centre, then every 16th tick after it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (centre_tick) begin
               state_d = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (full_tick && bit_cnt == 3'd7) begin
               state_d = parity_en ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (full_tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (full_tick) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bit capture: data shifted in LSB first, parity result and stop level held for the commit
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt   <= 3'd0;
         shift_reg <= 8'h00;
         par_err_q <= 1'b0;
         stop_q    <= 1'b1;
         commit_q  <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               bit_cnt <= 3'd0;
               if (start_edge) begin
                  par_err_q <= 1'b0;
               end
            end
            ST_DATA: begin
               if (full_tick) begin
                  shift_reg <= {rxs, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
            end
            ST_PARITY: begin
               if (full_tick) begin
                  if (par_q == 2'b10) begin
                     par_err_q <= ^shift_reg ^ rxs;
                  end else begin
                     par_err_q <= ~(^shift_reg ^ rxs);
                  end
               end
            end
            ST_STOP: begin
               if (full_tick) begin
                  stop_q   <= rxs;
                  commit_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output register and handshake: a commit always wins over a same-cycle acknowledge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out      <= 8'h00;
         data_valid    <= 1'b0;
         parity_error  <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else if (commit_q) begin
         data_out      <= shift_reg;
         parity_error  <= par_err_q;
         frame_error   <= ~stop_q;
         data_valid    <= 1'b1;
         overrun_error <= data_valid & ~data_ack;
      end else if (data_ack && data_valid) begin
         data_valid    <= 1'b0;
         overrun_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core with a frame-level reference model

module tb_uart_rx_core;

   localparam int D2400  = 20;
   localparam int D4800  = 10;
   localparam int D9600  = 6;
   localparam int D19200 = 4;

   logic       clock       = 1'b0;
   logic       reset_n     = 1'b0;
   logic [1:0] baud_rate   = 2'b10;
   logic [1:0] parity_type = 2'b00;
   logic       rx_serial   = 1'b1;
   logic       data_ack    = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       parity_error;
   logic       frame_error;
   logic       overrun_error;
   logic       busy;

   int errors = 0;
   int checks = 0;
   bit model_valid = 1'b0;

   uart_rx_core #(
      .DIV_2400 (D2400),
      .DIV_4800 (D4800),
      .DIV_9600 (D9600),
      .DIV_19200(D19200)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .baud_rate    (baud_rate),
      .parity_type  (parity_type),
      .rx_serial    (rx_serial),
      .data_ack     (data_ack),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .parity_error (parity_error),
      .frame_error  (frame_error),
      .overrun_error(overrun_error),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   function automatic int bit_clocks(input logic [1:0] b);
      case (b)
         2'b00:   return 16 * D2400;
         2'b01:   return 16 * D4800;
         2'b10:   return 16 * D9600;
         default: return 16 * D19200;
      endcase
   endfunction

   function automatic bit parity_on(input logic [1:0] p);
      return (p == 2'b01) || (p == 2'b10);
   endfunction

   // True when data plus the transmitted parity bit satisfy the selected parity rule
   function automatic bit parity_ok(input logic [7:0] d, input logic [1:0] p, input logic pb);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      ones += int'(pb);
      if (p == 2'b10) return (ones % 2) == 0;
      if (p == 2'b01) return (ones % 2) == 1;
      return 1'b1;
   endfunction

   function automatic int frame_bits(input logic [1:0] p);
      return parity_on(p) ? 11 : 10;
   endfunction

   // Serialise one frame; the line is left at the stop-bit level afterwards
   task automatic send_frame(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                             input logic pb, input logic stop_bit);
      int n;
      n = bit_clocks(b);
      @(negedge clock);
      rx_serial = 1'b0;
      repeat (n) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx_serial = d[i];
         repeat (n) @(negedge clock);
      end
      if (parity_on(p)) begin
         rx_serial = pb;
         repeat (n) @(negedge clock);
      end
      rx_serial = stop_bit;
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_ack;
      @(negedge clock) data_ack = 1'b1;
      @(negedge clock) data_ack = 1'b0;
   endtask

   task automatic test_reset;
      repeat (4) @(negedge clock);
      checks++;
      if ({data_out, data_valid, parity_error, frame_error, overrun_error, busy} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {data_out, data_valid, parity_error, frame_error, overrun_error, busy});
      end
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_even_ok;
      int cnt;
      int t_exp;
      cnt = 0;
      t_exp = D9600 * (16 * frame_bits(2'b10) - 8);
      baud_rate = 2'b10;
      parity_type = 2'b10;
      fork
         send_frame(8'hA5, 2'b10, 2'b10, 1'b0, 1'b1);
         begin
            @(negedge clock);
            while (data_valid !== 1'b1 && cnt < t_exp + 100) begin
               @(negedge clock);
               cnt++;
            end
         end
      join
      checks++;
      if (cnt < t_exp + 2 || cnt > t_exp + 6) begin
         errors++;
         $display("FAIL t1_latency: got %0d clocks expected %0d..%0d", cnt, t_exp + 2, t_exp + 6);
      end
      checks++;
      if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
         errors++;
         $display("FAIL t1_data: got %h/%b expected a5/1", data_out, data_valid);
      end
      checks++;
      if ({parity_error, frame_error, overrun_error} !== {~parity_ok(8'hA5, 2'b10, 1'b0), 2'b00}) begin
         errors++;
         $display("FAIL t1_flags: got %b expected 000", {parity_error, frame_error, overrun_error});
      end
      pulse_ack;
      checks++;
      if (data_valid !== 1'b0 || data_out !== 8'hA5) begin
         errors++;
         $display("FAIL t1_ack: got valid=%b data=%h expected 0/a5", data_valid, data_out);
      end
   endtask

   task automatic test_parity_error;
      send_frame(8'hA5, 2'b10, 2'b10, 1'b1, 1'b1);
      checks++;
      if (data_out !== 8'hA5 || parity_error !== ~parity_ok(8'hA5, 2'b10, 1'b1) || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL t2_parity: got data=%h pe=%b fe=%b expected a5/1/0", data_out, parity_error, frame_error);
      end
      pulse_ack;
   endtask

   task automatic test_frame_error;
      bit seen_valid;
      bit seen_busy;
      seen_valid = 1'b0;
      seen_busy = 1'b0;
      baud_rate = 2'b11;
      parity_type = 2'b00;
      send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0);
      checks++;
      if (data_out !== 8'h3C || frame_error !== 1'b1 || parity_error !== 1'b0 || data_valid !== 1'b1) begin
         errors++;
         $display("FAIL t3_frame: got data=%h fe=%b pe=%b v=%b expected 3c/1/0/1",
                  data_out, frame_error, parity_error, data_valid);
      end
      pulse_ack;
      for (int i = 0; i < 3 * bit_clocks(2'b11); i++) begin
         @(negedge clock);
         seen_valid |= data_valid;
         seen_busy |= busy;
      end
      checks++;
      if (seen_valid !== 1'b0 || seen_busy !== 1'b0) begin
         errors++;
         $display("FAIL t3_stuck_low: got valid=%b busy=%b expected 0/0", seen_valid, seen_busy);
      end
      rx_serial = 1'b1;
      repeat (10) @(negedge clock);
   endtask

   task automatic test_glitch;
      bit seen_valid;
      bit seen_busy;
      seen_valid = 1'b0;
      seen_busy = 1'b0;
      baud_rate = 2'b00;
      rx_serial = 1'b0;
      for (int i = 0; i < 16 * D2400; i++) begin
         if (i == 4 * D2400) rx_serial = 1'b1;
         @(negedge clock);
         seen_valid |= data_valid;
         seen_busy |= busy;
      end
      checks++;
      if (seen_busy !== 1'b1 || seen_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t4_glitch: got busy_seen=%b valid_seen=%b busy=%b expected 1/0/0",
                  seen_busy, seen_valid, busy);
      end
   endtask

   task automatic test_back_to_back;
      baud_rate = 2'b01;
      parity_type = 2'b00;
      send_frame(8'h11, 2'b01, 2'b00, 1'b0, 1'b1);
      checks++;
      if (data_out !== 8'h11 || overrun_error !== 1'b0) begin
         errors++;
         $display("FAIL t5_first: got data=%h ovr=%b expected 11/0", data_out, overrun_error);
      end
      send_frame(8'h22, 2'b01, 2'b00, 1'b0, 1'b1);
      checks++;
      if (data_out !== 8'h22 || overrun_error !== 1'b1 || data_valid !== 1'b1 || frame_error !== 1'b0) begin
         errors++;
         $display("FAIL t5_overrun: got data=%h ovr=%b v=%b fe=%b expected 22/1/1/0",
                  data_out, overrun_error, data_valid, frame_error);
      end
      pulse_ack;
      checks++;
      if (data_valid !== 1'b0 || overrun_error !== 1'b0 || data_out !== 8'h22) begin
         errors++;
         $display("FAIL t5_ack: got v=%b ovr=%b data=%h expected 0/0/22", data_valid, overrun_error, data_out);
      end
   endtask

   task automatic test_mid_reset;
      int n;
      n = bit_clocks(2'b10);
      baud_rate = 2'b10;
      parity_type = 2'b00;
      send_frame(8'h5A, 2'b10, 2'b00, 1'b0, 1'b1);
      fork
         send_frame(8'hC3, 2'b10, 2'b00, 1'b0, 1'b1);
         begin
            repeat (5 * n + n / 2) @(negedge clock);
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL t6_in_frame: got busy=%b expected 1", busy);
            end
            reset_n = 1'b0;
            repeat (3) @(negedge clock);
            checks++;
            if ({data_out, data_valid, parity_error, frame_error, overrun_error, busy} !== 13'd0) begin
               errors++;
               $display("FAIL t6_reset_outputs: got %h expected 0",
                        {data_out, data_valid, parity_error, frame_error, overrun_error, busy});
            end
         end
      join
      repeat (5) @(negedge clock);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      send_frame(8'h7E, 2'b10, 2'b00, 1'b0, 1'b1);
      checks++;
      if (data_out !== 8'h7E || data_valid !== 1'b1 ||
          {parity_error, frame_error, overrun_error} !== 3'b000) begin
         errors++;
         $display("FAIL t6_after_reset: got data=%h v=%b flags=%b expected 7e/1/000",
                  data_out, data_valid, {parity_error, frame_error, overrun_error});
      end
      pulse_ack;
   endtask

   task automatic test_random;
      logic [1:0] b;
      logic [1:0] p;
      logic [7:0] d;
      logic       pb;
      logic       sb;
      logic       ack_it;
      logic       exp_pe;
      pulse_ack;
      model_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         b = 2'($urandom_range(0, 3));
         p = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         pb = 1'($urandom_range(0, 1));
         sb = ($urandom_range(0, 4) != 0);
         ack_it = 1'($urandom_range(0, 1));
         baud_rate = b;
         parity_type = p;
         fork
            send_frame(d, b, p, pb, sb);
            begin
               repeat (2 * bit_clocks(b)) @(negedge clock);
               baud_rate = 2'($urandom_range(0, 3));
               parity_type = 2'($urandom_range(0, 3));
            end
         join
         exp_pe = parity_on(p) ? ~parity_ok(d, p, pb) : 1'b0;
         checks++;
         if (data_out !== d || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL rnd%0d_data: got %h/%b expected %h/1 (baud=%0d par=%0d)", k, data_out, data_valid, d, b, p);
         end
         checks++;
         if ({parity_error, frame_error, overrun_error} !== {exp_pe, ~sb, model_valid}) begin
            errors++;
            $display("FAIL rnd%0d_flags: got %b expected %b", k,
                     {parity_error, frame_error, overrun_error}, {exp_pe, ~sb, model_valid});
         end
         model_valid = 1'b1;
         rx_serial = 1'b1;
         if (ack_it) begin
            pulse_ack;
            model_valid = 1'b0;
            checks++;
            if (data_valid !== 1'b0 || overrun_error !== 1'b0) begin
               errors++;
               $display("FAIL rnd%0d_ack: got v=%b ovr=%b expected 0/0", k, data_valid, overrun_error);
            end
         end
         repeat (8) @(negedge clock);
      end
   endtask

   initial begin
      test_reset;
      test_even_ok;
      test_parity_error;
      test_frame_error;
      test_glitch;
      test_back_to_back;
      test_mid_reset;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
